multicycle_ex_sequencer: RTL and testbench

Sequences the multi-cycle execution resources (M unit, A unit, FPU) for the instruction sitting in ID/EX. It issues one start pulse to the selected unit and holds ID/EX and EX/MEM while the unit runs. It releases the pipeline for exactly one cycle on completion and raises a front-end stall consumed by the hazard detection logic. A watchdog aborts ops that never complete, and a flush from branch or trap handling cancels an op in flight.

---
 rtl/multicycle_ex_sequencer_pkg.sv | 29 ++
 rtl/multicycle_ex_sequencer_watchdog.sv | 37 +++
 rtl/multicycle_ex_sequencer.sv | 175 +++++++++++++++++
 tb/tb_multicycle_ex_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ex_sequencer_pkg.sv
// Purpose : shared state and unit encodings for the multi-cycle EX sequencer.
// Latency : n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package multicycle_ex_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY     = 2'd1,
    ST_COMPLETE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    UNIT_NONE = 2'b00,
    UNIT_M    = 2'b01,
    UNIT_A    = 2'b10,
    UNIT_FP   = 2'b11
  } unit_t;

  localparam int DEFAULT_TIMEOUT = 64;

  // Fixed priority M > A > FP; lower-priority flags are dropped.
  function automatic unit_t sel_unit(input logic is_md, input logic is_at, input logic is_fp);
    if (is_md)      return UNIT_M;
    else if (is_at) return UNIT_A;
    else if (is_fp) return UNIT_FP;
    else            return UNIT_NONE;
  endfunction

endpackage

// File: rtl/multicycle_ex_sequencer_watchdog.sv
// Purpose : saturating busy-cycle counter that flags when an op has run too long.
// Latency : o_expire is combinational from the count; count updates each clock.
// Backpressure: none; i_enable simply freezes the count.
// Ports:
//   i_clk, i_reset   core clock, async active-high reset
//   i_clear          force count to 0 (held while the sequencer is not busy)
//   i_enable         advance the count by one this cycle
//   o_expire         count has reached TIMEOUT_CYCLES-1
module exsq_watchdog #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // Stops at LAST so a stuck op can never wrap the count back to zero.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = (r_cnt == LAST);

endmodule

// File: rtl/multicycle_ex_sequencer.sv
// Purpose : issues one start to the M/A/FP unit for the op in ID/EX, freezes ID/EX and
//           EX/MEM plus the front end while it runs, releases for one cycle on completion.
// Latency : start is Mealy in the issue cycle; result_valid one cycle after done/timeout.
// Backpressure: the pipeline is held (hold_*/stall_front) for the whole op; flush cancels.
// Ports:
//   i_clk, i_reset                       core clock, async active-high reset
//   i_idex_valid, i_idex_is_mul_div,
//   i_idex_is_atomic, i_idex_fp_multicycle  ID/EX op qualifiers
//   i_flush                              branch/trap flush
//   i_mul_div_done, i_atomic_done, i_fpu_done  unit completion pulses
//   o_start_*                            1-cycle start pulse per unit
//   o_unit_abort                         cancel pulse to the active unit
//   o_hold_idex, o_hold_exmem, o_stall_front  pipeline freeze
//   o_result_valid                       result accepted this cycle
//   o_timeout_err                        sticky watchdog error
//   o_active_unit                        00 none, 01 M, 10 A, 11 FP
module multicycle_ex_sequencer
  import multicycle_ex_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int CNT_W          = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_idex_valid,
  input  logic       i_idex_is_mul_div,
  input  logic       i_idex_is_atomic,
  input  logic       i_idex_fp_multicycle,
  input  logic       i_flush,
  input  logic       i_mul_div_done,
  input  logic       i_atomic_done,
  input  logic       i_fpu_done,
  output logic       o_start_mul_div,
  output logic       o_start_atomic,
  output logic       o_start_fpu,
  output logic       o_unit_abort,
  output logic       o_hold_idex,
  output logic       o_hold_exmem,
  output logic       o_stall_front,
  output logic       o_result_valid,
  output logic       o_timeout_err,
  output logic [1:0] o_active_unit
);

  state_t r_state;
  state_t w_next;
  unit_t  r_active_unit;
  logic   r_timeout_err;

  logic   w_issue;
  unit_t  w_sel;
  logic   w_done;
  logic   w_expire;
  logic   w_timeout;
  logic   w_busy;

  logic   w_start_md, w_start_at, w_start_fp;
  logic   w_abort, w_hold, w_result_valid;

  // Reset is folded into issue so the Mealy start path stays quiet while reset is held.
  assign w_issue = ~i_reset & i_idex_valid & ~i_flush &
                   (i_idex_is_mul_div | i_idex_is_atomic | i_idex_fp_multicycle);
  assign w_sel   = sel_unit(i_idex_is_mul_div, i_idex_is_atomic, i_idex_fp_multicycle);
  assign w_busy  = (r_state == ST_BUSY);

  // Only the latched unit's done is observed; strays from other units are dropped.
  always_comb begin
    w_done = 1'b0;
    case (r_active_unit)
      UNIT_M:  w_done = i_mul_div_done;
      UNIT_A:  w_done = i_atomic_done;
      UNIT_FP: w_done = i_fpu_done;
      default: w_done = 1'b0;
    endcase
  end

  exsq_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (~w_busy),
    .i_enable (w_busy),
    .o_expire (w_expire)
  );

  // Done beats a coincident expiry; flush beats both.
  assign w_timeout = w_busy & w_expire & ~w_done & ~i_flush;

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_issue) w_next = ST_BUSY;
      end
      ST_BUSY: begin
        if (i_flush)                 w_next = ST_IDLE;
        else if (w_done || w_expire) w_next = ST_COMPLETE;
      end
      ST_COMPLETE: w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    w_start_md     = 1'b0;
    w_start_at     = 1'b0;
    w_start_fp     = 1'b0;
    w_abort        = 1'b0;
    w_hold         = 1'b0;
    w_result_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_issue) begin
          w_start_md = (w_sel == UNIT_M);
          w_start_at = (w_sel == UNIT_A);
          w_start_fp = (w_sel == UNIT_FP);
          w_hold     = 1'b1;
        end
      end
      ST_BUSY: begin
        if (i_flush) begin
          w_abort = 1'b1;
        end else begin
          w_hold  = 1'b1;
          w_abort = w_timeout;
        end
      end
      // Result is accepted even after a timeout so the pipeline drains; never restart here.
      ST_COMPLETE: w_result_valid = ~i_flush;
      default: ;
    endcase
  end

  // Unit latch and sticky error.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_active_unit <= UNIT_NONE;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_issue) begin
        r_active_unit <= w_sel;
      end else if ((w_busy && i_flush) || r_state == ST_COMPLETE) begin
        r_active_unit <= UNIT_NONE;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign o_start_mul_div = w_start_md;
  assign o_start_atomic  = w_start_at;
  assign o_start_fpu     = w_start_fp;
  assign o_unit_abort    = w_abort;
  assign o_hold_idex     = w_hold;
  assign o_hold_exmem    = w_hold;
  assign o_stall_front   = w_hold;
  assign o_result_valid  = w_result_valid;
  assign o_timeout_err   = r_timeout_err;
  assign o_active_unit   = r_active_unit;

endmodule

// File: tb/tb_multicycle_ex_sequencer.sv
// Scoreboard bench for the multi-cycle EX sequencer: two instances (default watchdog and an
// 8-cycle watchdog); stimulus pushes expected events and hold-run lengths, a negedge monitor
// pops and compares whenever a start/abort/result_valid appears or a hold run ends.
module tb_multicycle_ex_sequencer;

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  st;   // {fpu, atomic, mul_div} starts
    logic        ab;
    logic        rv;
    logic [1:0]  un;
    logic        te;
    logic [2:0]  hd;   // {hold_idex, hold_exmem, stall_front}
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] valid, md, at, fp, flush, mdone, adone, fdone;
  logic [1:0] smd, sat, sfp, abrt, hid, hex, stl, rv, terr;
  logic [1:0] un0, un1;

  multicycle_ex_sequencer dut_a (
    .i_clk(clk), .i_reset(rst),
    .i_idex_valid(valid[0]), .i_idex_is_mul_div(md[0]), .i_idex_is_atomic(at[0]),
    .i_idex_fp_multicycle(fp[0]), .i_flush(flush[0]),
    .i_mul_div_done(mdone[0]), .i_atomic_done(adone[0]), .i_fpu_done(fdone[0]),
    .o_start_mul_div(smd[0]), .o_start_atomic(sat[0]), .o_start_fpu(sfp[0]),
    .o_unit_abort(abrt[0]), .o_hold_idex(hid[0]), .o_hold_exmem(hex[0]),
    .o_stall_front(stl[0]), .o_result_valid(rv[0]), .o_timeout_err(terr[0]),
    .o_active_unit(un0)
  );

  multicycle_ex_sequencer #(.TIMEOUT_CYCLES(8), .CNT_W(8)) dut_b (
    .i_clk(clk), .i_reset(rst),
    .i_idex_valid(valid[1]), .i_idex_is_mul_div(md[1]), .i_idex_is_atomic(at[1]),
    .i_idex_fp_multicycle(fp[1]), .i_flush(flush[1]),
    .i_mul_div_done(mdone[1]), .i_atomic_done(adone[1]), .i_fpu_done(fdone[1]),
    .o_start_mul_div(smd[1]), .o_start_atomic(sat[1]), .o_start_fpu(sfp[1]),
    .o_unit_abort(abrt[1]), .o_hold_idex(hid[1]), .o_hold_exmem(hex[1]),
    .o_stall_front(stl[1]), .o_result_valid(rv[1]), .o_timeout_err(terr[1]),
    .o_active_unit(un1)
  );

  ev_t q0[$], q1[$];
  int  h0[$], h1[$];
  int  hr[2];
  int  checks = 0;
  int  errors = 0;

  function automatic ev_t mk(input int c, input logic [2:0] st, input logic ab, input logic r,
                             input logic [1:0] u, input logic te, input logic [2:0] hd);
    ev_t e;
    e.cyc = c; e.st = st; e.ab = ab; e.rv = r; e.un = u; e.te = te; e.hd = hd;
    return e;
  endfunction

  task automatic push_ev(input int b, input ev_t e);
    if (b == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic push_hold(input int b, input int n);
    if (b == 0) h0.push_back(n); else h1.push_back(n);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue an op at the current cycle, pulse done_sel done_at cycles later, then step into IDLE.
  task automatic op(input int b, input logic [2:0] flags, input logic [2:0] dsel, input int done_at,
                    input logic [2:0] est, input logic [1:0] eun, input logic ete, input bit keep);
    int c;
    c = cyc;
    valid[b] = 1'b1;
    {fp[b], at[b], md[b]} = flags;
    push_ev(b, mk(c, est, 1'b0, 1'b0, 2'b00, ete, 3'b111));
    push_ev(b, mk(c + done_at + 1, 3'b000, 1'b0, 1'b1, eun, ete, 3'b000));
    push_hold(b, done_at + 1);
    tick(done_at);
    {fdone[b], adone[b], mdone[b]} = dsel;
    tick(1);
    {fdone[b], adone[b], mdone[b]} = 3'b000;
    tick(1);
    if (!keep) begin
      valid[b] = 1'b0;
      {fp[b], at[b], md[b]} = 3'b000;
    end
  endtask

  task automatic mon_dut(input int b);
    ev_t g, e;
    g.cyc = cyc;
    g.st  = {sfp[b], sat[b], smd[b]};
    g.ab  = abrt[b];
    g.rv  = rv[b];
    g.un  = (b == 0) ? un0 : un1;
    g.te  = terr[b];
    g.hd  = {hid[b], hex[b], stl[b]};
    if (g.st != 3'b000 || g.ab || g.rv) begin
      checks++;
      if ((b == 0 && q0.size() == 0) || (b == 1 && q1.size() == 0)) begin
        errors++;
        $display("FAIL unexpected_event dut%0d: got cyc=%0d st=%b ab=%b rv=%b un=%b te=%b hd=%b, none expected",
                 b, g.cyc, g.st, g.ab, g.rv, g.un, g.te, g.hd);
      end else begin
        e = (b == 0) ? q0.pop_front() : q1.pop_front();
        if (g != e) begin
          errors++;
          $display("FAIL event dut%0d: got cyc=%0d st=%b ab=%b rv=%b un=%b te=%b hd=%b, want cyc=%0d st=%b ab=%b rv=%b un=%b te=%b hd=%b",
                   b, g.cyc, g.st, g.ab, g.rv, g.un, g.te, g.hd, e.cyc, e.st, e.ab, e.rv, e.un, e.te, e.hd);
        end
      end
    end
    if (g.hd != 3'b000) begin
      hr[b]++;
    end else if (hr[b] > 0) begin
      int want;
      checks++;
      if ((b == 0 && h0.size() == 0) || (b == 1 && h1.size() == 0)) begin
        errors++;
        $display("FAIL hold_run dut%0d: got run of %0d cycles ending at %0d, none expected", b, hr[b], cyc);
      end else begin
        want = (b == 0) ? h0.pop_front() : h1.pop_front();
        if (hr[b] != want) begin
          errors++;
          $display("FAIL hold_run dut%0d: got %0d cycles, want %0d", b, hr[b], want);
        end
      end
      hr[b] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        logic [11:0] o;
        o = {smd[b], sat[b], sfp[b], abrt[b], hid[b], hex[b], stl[b], rv[b], terr[b], 1'b0,
             (b == 0) ? un0 : un1};
        checks++;
        if (o != 12'h000) begin
          errors++;
          $display("FAIL reset_outputs dut%0d: got %b, want all zero", b, o);
        end
      end
    end
    mon_dut(0);
    mon_dut(1);
  end

  initial begin
    int c;
    hr[0] = 0; hr[1] = 0;
    rst = 1'b1;
    valid = '0; md = '0; at = '0; fp = '0; flush = '0; mdone = '0; adone = '0; fdone = '0;
    tick(3);
    rst = 1'b0;
    tick(2);

    // M op, done 32 cycles after start.
    op(0, 3'b001, 3'b001, 32, 3'b001, 2'b01, 1'b0, 1'b0);
    tick(2);

    // Two back-to-back atomic ops; starts 6 cycles apart, none in COMPLETE.
    op(0, 3'b010, 3'b010, 4, 3'b010, 2'b10, 1'b0, 1'b1);
    op(0, 3'b010, 3'b010, 4, 3'b010, 2'b10, 1'b0, 1'b0);
    tick(2);

    // M and FP both flagged: M wins, stray fpu_done ignored.
    c = cyc;
    valid[0] = 1'b1; md[0] = 1'b1; fp[0] = 1'b1;
    push_ev(0, mk(c, 3'b001, 1'b0, 1'b0, 2'b00, 1'b0, 3'b111));
    push_ev(0, mk(c + 6, 3'b000, 1'b0, 1'b1, 2'b01, 1'b0, 3'b000));
    push_hold(0, 6);
    tick(2); fdone[0] = 1'b1;
    tick(1); fdone[0] = 1'b0;
    tick(2); mdone[0] = 1'b1;
    tick(1); mdone[0] = 1'b0;
    tick(1); valid[0] = 1'b0; md[0] = 1'b0; fp[0] = 1'b0;
    tick(2);

    // Flush on 5th BUSY cycle of an FP op; late fpu_done ignored.
    c = cyc;
    valid[0] = 1'b1; fp[0] = 1'b1;
    push_ev(0, mk(c, 3'b100, 1'b0, 1'b0, 2'b00, 1'b0, 3'b111));
    push_ev(0, mk(c + 5, 3'b000, 1'b1, 1'b0, 2'b11, 1'b0, 3'b000));
    push_hold(0, 5);
    tick(5); flush[0] = 1'b1;
    tick(1); flush[0] = 1'b0; valid[0] = 1'b0; fp[0] = 1'b0;
    tick(1); fdone[0] = 1'b1;
    tick(1); fdone[0] = 1'b0;
    tick(2);

    // Flush in IDLE blocks issue.
    valid[0] = 1'b1; md[0] = 1'b1; flush[0] = 1'b1;
    tick(2);
    valid[0] = 1'b0; md[0] = 1'b0; flush[0] = 1'b0;
    tick(2);

    // Flush in COMPLETE suppresses result_valid.
    c = cyc;
    valid[0] = 1'b1; md[0] = 1'b1;
    push_ev(0, mk(c, 3'b001, 1'b0, 1'b0, 2'b00, 1'b0, 3'b111));
    push_hold(0, 2);
    tick(1); mdone[0] = 1'b1;
    tick(1); mdone[0] = 1'b0; flush[0] = 1'b1;
    tick(1); flush[0] = 1'b0; valid[0] = 1'b0; md[0] = 1'b0;
    tick(2);

    // 8-cycle watchdog: done on the expiry cycle wins, no abort, no error.
    op(1, 3'b100, 3'b100, 8, 3'b100, 2'b11, 1'b0, 1'b0);
    tick(2);

    // 8-cycle watchdog: FPU never completes.
    c = cyc;
    valid[1] = 1'b1; fp[1] = 1'b1;
    push_ev(1, mk(c, 3'b100, 1'b0, 1'b0, 2'b00, 1'b0, 3'b111));
    push_ev(1, mk(c + 8, 3'b000, 1'b1, 1'b0, 2'b11, 1'b0, 3'b111));
    push_ev(1, mk(c + 9, 3'b000, 1'b0, 1'b1, 2'b11, 1'b1, 3'b000));
    push_hold(1, 9);
    tick(9);
    tick(1); valid[1] = 1'b0; fp[1] = 1'b0;
    tick(2);

    // Error stays set across a later successful op.
    op(1, 3'b001, 3'b001, 2, 3'b001, 2'b01, 1'b1, 1'b0);
    tick(2);

    // Reset mid-BUSY: outputs drop at once, no abort; new op afterwards.
    c = cyc;
    valid[0] = 1'b1; md[0] = 1'b1;
    push_ev(0, mk(c, 3'b001, 1'b0, 1'b0, 2'b00, 1'b0, 3'b111));
    push_hold(0, 3);
    tick(3);
    #1 rst = 1'b1;
    valid[0] = 1'b0; md[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    tick(1);
    op(0, 3'b001, 3'b001, 2, 3'b001, 2'b01, 1'b0, 1'b0);
    tick(5);

    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL events_left: got %0d/%0d unconsumed, want 0/0", q0.size(), q1.size());
    end
    checks++;
    if (h0.size() != 0 || h1.size() != 0) begin
      errors++;
      $display("FAIL holds_left: got %0d/%0d unconsumed, want 0/0", h0.size(), h1.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
